// File: rtl/proc_pkg.sv
// Shared processor-datapath types and defaults used by the register file,
// its bus interface and its read ports.
package proc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    typedef logic [DATA_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

    // Scoreboard flag per register: a reserved destination stays PENDING until written back.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } busy_state_e;

    function automatic logic idx_in_range(input int unsigned idx, input int unsigned depth);
        return idx < depth;
    endfunction

    // A live index holds real state: in range and not the hardwired zero register.
    function automatic logic idx_live(input int unsigned idx, input int unsigned depth,
                                      input bit zero_reg);
        return (idx < depth) && !(zero_reg && (idx == 0));
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-side bus of the register file: writeback, two read ports
// and the reservation channel into the busy scoreboard.
interface reg_file_sb_if
    import proc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy_a;
    logic              busy_b;

    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_conflict;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_addr_a, rd_addr_b,
        output rsv_en, rsv_addr,
        input  rd_data_a, rd_data_b, busy_a, busy_b, rsv_conflict
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_addr_a, rd_addr_b,
        input  rsv_en, rsv_addr,
        output rd_data_a, rd_data_b, busy_a, busy_b, rsv_conflict
    );

endinterface

// File: rtl/reg_file_sb_port.sv
// One registered read port: range/zero-register check, write-first bypass
// and busy lookup, all captured together so data and busy stay aligned.
module reg_file_sb_port
    import proc_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_ok,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_accept,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [DATA_W-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0]  busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0]  rd_idx;
    logic              addr_live;
    logic [DATA_W-1:0] rd_data_d, rd_data_q;
    logic              rd_busy_d, rd_busy_q;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value held over from a previous evaluation and infer a latch.
    always_comb begin
        rd_idx    = IDX_W'(rd_addr);
        addr_live = idx_live(32'(rd_addr), DEPTH, ZERO_REG != 0);
        rd_data_d = '0;
        rd_busy_d = 1'b0;
        if (addr_live) begin
            if (wr_ok && (wr_addr == rd_addr)) begin
                // Write-first: a same-cycle reservation of this index keeps it busy.
                rd_data_d = wr_data;
                rd_busy_d = rsv_accept && (rsv_addr == rd_addr);
            end else begin
                rd_data_d = regs[rd_idx];
                rd_busy_d = busy[rd_idx];
            end
        end
    end

    // NOTE: non-blocking assignments in clocked blocks, so every flop samples
    // the pre-edge value of its _d regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
            rd_busy_q <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with two registered read ports, write-to-read
// bypass and a per-register busy scoreboard (reserve at issue, clear at writeback).
module reg_file_sb
    import proc_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic         clock,
    input  logic         reset,
    reg_file_sb_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    busy_state_e       busy_q [DEPTH];
    busy_state_e       busy_d [DEPTH];
    logic [DEPTH-1:0]  busy_vec;
    logic              rsv_conflict_q, rsv_conflict_d;

    logic              wr_ok;
    logic              rsv_ok;
    logic              rsv_in_range;
    logic              rsv_is_busy;
    logic              wr_hits_rsv;
    logic              rsv_accept;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rsv_idx;

    assign wr_idx  = IDX_W'(bus.wr_addr);
    assign rsv_idx = IDX_W'(bus.rsv_addr);

    always_comb begin
        wr_ok        = bus.wr_en && idx_live(32'(bus.wr_addr), DEPTH, ZERO_REG != 0);
        rsv_ok       = bus.rsv_en && idx_live(32'(bus.rsv_addr), DEPTH, ZERO_REG != 0);
        rsv_in_range = idx_in_range(32'(bus.rsv_addr), DEPTH);
        rsv_is_busy  = rsv_in_range && (busy_q[rsv_idx] == PENDING);
        wr_hits_rsv  = wr_ok && (bus.wr_addr == bus.rsv_addr);

        // A busy register may be re-reserved only in the cycle it is written back.
        rsv_accept     = rsv_ok && (!rsv_is_busy || wr_hits_rsv);
        rsv_conflict_d = bus.rsv_en &&
                         (!rsv_in_range || (rsv_ok && rsv_is_busy && !wr_hits_rsv));

        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[wr_idx] = bus.wr_data;
            busy_d[wr_idx] = IDLE;
        end
        if (rsv_accept) begin
            busy_d[rsv_idx] = PENDING;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_vec[i] = (busy_q[i] == PENDING);
        end
    end

    // NOTE: the storage array is reset along with the control flops because
    // software relies on every register reading 0 after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
                busy_q[i] <= IDLE;
            end
            rsv_conflict_q <= 1'b0;
        end else begin
            regs_q         <= regs_d;
            busy_q         <= busy_d;
            rsv_conflict_q <= rsv_conflict_d;
        end
    end

    assign bus.rsv_conflict = rsv_conflict_q;

    reg_file_sb_port #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_port_a (
        .clock     (clock),
        .reset     (reset),
        .rd_addr   (bus.rd_addr_a),
        .wr_ok     (wr_ok),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .rsv_accept(rsv_accept),
        .rsv_addr  (bus.rsv_addr),
        .regs      (regs_q),
        .busy      (busy_vec),
        .rd_data   (bus.rd_data_a),
        .rd_busy   (bus.busy_a)
    );

    reg_file_sb_port #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_port_b (
        .clock     (clock),
        .reset     (reset),
        .rd_addr   (bus.rd_addr_b),
        .wr_ok     (wr_ok),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .rsv_accept(rsv_accept),
        .rsv_addr  (bus.rsv_addr),
        .regs      (regs_q),
        .busy      (busy_vec),
        .rd_data   (bus.rd_data_b),
        .rd_busy   (bus.busy_b)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: a 16-entry plain config and a 12-entry
// zero-register config see identical stimulus, each against its own reference model.
module tb_reg_file_sb;
    import proc_pkg::*;

    typedef struct packed {
        word_t rd_a;
        word_t rd_b;
        logic  busy_a;
        logic  busy_b;
        logic  conflict;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(4)) bus0 ();
    reg_file_sb_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();

    reg_file_sb #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .ZERO_REG(0)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0)
    );
    reg_file_sb #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .ZERO_REG(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1)
    );

    // Reference state: architectural register contents and pending flags per config.
    word_t m_mem  [2][16];
    bit    m_busy [2][16];
    exp_t  q0 [$];
    exp_t  q1 [$];

    function automatic int depth_of(int k);
        return (k == 0) ? 16 : 12;
    endfunction

    function automatic bit live(int k, int idx);
        return (idx < depth_of(k)) && !((k == 1) && (idx == 0));
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) begin
                m_mem[k][i]  = '0;
                m_busy[k][i] = 1'b0;
            end
    endfunction

    function automatic exp_t model_step(int k, bit we, int wa, word_t wd,
                                        int ra, int rb, bit re, int rsa);
        exp_t e;
        bit   wr_ok;
        bit   hit;
        bit   accept;
        wr_ok  = we && live(k, wa);
        hit    = wr_ok && (wa == rsa);
        accept = re && live(k, rsa) && (!m_busy[k][rsa] || hit);
        e.conflict = re && ((rsa >= depth_of(k)) || (live(k, rsa) && m_busy[k][rsa] && !hit));
        for (int p = 0; p < 2; p++) begin
            int    r;
            word_t d;
            bit    b;
            r = (p == 0) ? ra : rb;
            if (!live(k, r)) begin
                d = '0;
                b = 1'b0;
            end else if (wr_ok && (wa == r)) begin
                d = wd;
                b = accept && (rsa == r);
            end else begin
                d = m_mem[k][r];
                b = m_busy[k][r];
            end
            if (p == 0) begin e.rd_a = d; e.busy_a = b; end
            else        begin e.rd_b = d; e.busy_b = b; end
        end
        if (wr_ok) begin
            m_mem[k][wa]  = wd;
            m_busy[k][wa] = 1'b0;
        end
        if (accept) m_busy[k][rsa] = 1'b1;
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(string tag, exp_t e, word_t a, word_t b,
                           logic ba, logic bb, logic c);
        check({tag, ".rd_data_a"}, 64'(a), 64'(e.rd_a));
        check({tag, ".rd_data_b"}, 64'(b), 64'(e.rd_b));
        check({tag, ".busy_a"}, 64'(ba), 64'(e.busy_a));
        check({tag, ".busy_b"}, 64'(bb), 64'(e.busy_b));
        check({tag, ".rsv_conflict"}, 64'(c), 64'(e.conflict));
    endtask

    task automatic set_inputs(bit we, int wa, word_t wd, int ra, int rb, bit re, int rsa);
        bus0.wr_en = we; bus0.wr_addr = 4'(wa); bus0.wr_data = wd;
        bus0.rd_addr_a = 4'(ra); bus0.rd_addr_b = 4'(rb);
        bus0.rsv_en = re; bus0.rsv_addr = 4'(rsa);
        bus1.wr_en = we; bus1.wr_addr = 4'(wa); bus1.wr_data = wd;
        bus1.rd_addr_a = 4'(ra); bus1.rd_addr_b = 4'(rb);
        bus1.rsv_en = re; bus1.rsv_addr = 4'(rsa);
    endtask

    // One cycle of stimulus; the expected registered response is queued for the monitor.
    task automatic drive(bit we, int wa, word_t wd, int ra, int rb, bit re, int rsa);
        @(negedge clock);
        set_inputs(we, wa, wd, ra, rb, re, rsa);
        q0.push_back(model_step(0, we, wa, wd, ra, rb, re, rsa));
        q1.push_back(model_step(1, we, wa, wd, ra, rb, re, rsa));
    endtask

    // Reset lands between clock edges; outputs must clear without waiting for an edge.
    task automatic apply_reset(string tag);
        @(negedge clock);
        set_inputs(1'b0, 0, '0, 0, 0, 1'b0, 0);
        #2 reset = 1'b1;
        #1;
        compare({tag, ".dut0"}, '0, bus0.rd_data_a, bus0.rd_data_b,
                bus0.busy_a, bus0.busy_b, bus0.rsv_conflict);
        compare({tag, ".dut1"}, '0, bus1.rd_data_a, bus1.rd_data_b,
                bus1.busy_a, bus1.busy_b, bus1.rsv_conflict);
        model_reset();
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                if (q0.size() > 0)
                    compare("dut0", q0.pop_front(), bus0.rd_data_a, bus0.rd_data_b,
                            bus0.busy_a, bus0.busy_b, bus0.rsv_conflict);
                if (q1.size() > 0)
                    compare("dut1", q1.pop_front(), bus1.rd_data_a, bus1.rd_data_b,
                            bus1.busy_a, bus1.busy_b, bus1.rsv_conflict);
            end
        end
    end

    initial begin
        set_inputs(1'b0, 0, '0, 0, 0, 1'b0, 0);
        model_reset();
        apply_reset("reset_init");

        // Reset mid-run: reg3 written and reserved, then cleared asynchronously.
        drive(1, 3, 32'hDEADBEEF, 3, 3, 1, 3);
        apply_reset("reset_mid");
        drive(0, 0, '0, 3, 3, 0, 0);

        // Write then read.
        drive(1, 5, 32'h0000_0123, 0, 0, 0, 0);
        drive(0, 0, '0, 5, 5, 0, 0);

        // Bypass on both ports.
        drive(1, 7, 32'hCAFE_0001, 7, 7, 0, 0);

        // Scoreboard: reserve, observe busy, conflicting re-reserve, writeback.
        drive(0, 0, '0, 0, 0, 1, 9);
        drive(0, 0, '0, 9, 9, 0, 0);
        drive(0, 0, '0, 9, 0, 1, 9);
        drive(1, 9, 32'h0000_0010, 0, 9, 0, 0);
        drive(0, 0, '0, 9, 9, 0, 0);

        // Write + reserve of an already-busy index.
        drive(0, 0, '0, 0, 0, 1, 4);
        drive(1, 4, 32'h0000_0055, 4, 0, 1, 4);
        drive(0, 0, '0, 4, 4, 0, 0);

        // Zero register and out-of-range indices (out of range only for the 12-entry config).
        drive(1, 0, 32'h0000_00FF, 0, 13, 0, 0);
        drive(1, 13, 32'h0000_0001, 0, 13, 0, 0);
        drive(0, 0, '0, 0, 13, 1, 13);
        drive(0, 0, '0, 0, 13, 1, 0);
        drive(0, 0, '0, 12, 11, 1, 11);

        // Randomised traffic with collisions biased in, split by a second reset.
        for (int i = 0; i < 600; i++) begin
            bit    we, re;
            int    wa, ra, rb, rsa;
            word_t wd;
            if (i == 300) apply_reset("reset_rand");
            we  = ($urandom_range(0, 99) < 55);
            re  = ($urandom_range(0, 99) < 45);
            wa  = $urandom_range(0, 15);
            wd  = $urandom;
            ra  = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 15);
            rsa = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
            drive(we, wa, wd, ra, rb, re, rsa);
        end

        repeat (3) @(negedge clock);
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file: successor to the 16x32 processor register bank.
- Configurable width and depth; two independent registered read ports; one write port with write-to-read bypass.
- Optional hardwired zero register.
- Per-register busy scoreboard: the control unit reserves a destination at issue, and writeback clears it. Sits between decode and the ALU/writeback stage.

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 16, number of registers (2..64, any value, not only powers of 2)
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH
- ZERO_REG, 0, when 1, register 0 always reads 0 and is never busy or written

Ports:
- clock  in  1  system clock, rising edge active
- reset  in  1  reset, asynchronous, active-high
- wr_en  in  1  writeback enable
- wr_addr  in  ADDR_W  writeback register index
- wr_data  in  DATA_W  writeback data
- rd_addr_a  in  ADDR_W  read port A index
- rd_addr_b  in  ADDR_W  read port B index
- rd_data_a  out  DATA_W  read port A data (registered)
- rd_data_b  out  DATA_W  read port B data (registered)
- busy_a  out  1  register at rd_addr_a has a pending write (registered, aligned with rd_data_a)
- busy_b  out  1  same, for port B
- rsv_en  in  1  reserve request: mark destination busy
- rsv_addr  in  ADDR_W  register index to reserve
- rsv_conflict  out  1  one-cycle pulse: reservation refused

Behaviour:
- Reset (async, any time, including mid-operation):
  - All registers clear to 0 and all busy bits clear.
  - rd_data_a, rd_data_b clear to 0; busy_a, busy_b, rsv_conflict clear to 0.
  - The first rising edge after deassertion behaves normally.
- Timing: all state updates on the rising clock edge; no negedge logic.
- Write: if wr_en and wr_addr < DEPTH (and not index 0 when ZERO_REG=1), then reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Read latency is 1 cycle: rd_data_x <= reg[rd_addr_x] and busy_x <= busy[rd_addr_x].
- Bypass: if wr_en and wr_addr == rd_addr_x in the same cycle (valid, writable index):
  - rd_data_x takes wr_data (write-first).
  - busy_x takes 0, unless the same index is also reserved that cycle; then busy_x takes 1.
- Both ports may read the same index; both receive identical data.
- Reserve:
  - If rsv_en and the index is valid, writable and not busy, set busy[rsv_addr] <= 1.
  - If the index is already busy and not being written this cycle, ignore the request and set rsv_conflict <= 1 for one cycle.
  - Reserve and write to the same index in the same cycle: the write updates data, busy ends up 1 (the new reservation wins), and no conflict is raised.
- Out-of-range index (>= DEPTH):
  - Read returns data 0 and busy 0.
  - Write is ignored.
  - Reserve is ignored and pulses rsv_conflict.
- ZERO_REG=1:
  - Index 0 reads 0 with busy 0.
  - Write to index 0 is ignored.
  - Reserve of index 0 is accepted silently with no effect and no conflict.
- Initial contents other than reset are undefined; no initial blocks.
- Not a state machine per register: the busy bit is a 2-state flag, IDLE <-> PENDING.
  - IDLE -> PENDING on an accepted reserve.
  - PENDING -> IDLE on a write.
  - PENDING -> PENDING on write plus reserve in the same cycle.

Decomposition:
- Shared package proc_pkg holds DATA_W/ADDR_W defaults and the reg_idx_t and word_t typedefs.
- One natural sub-module, reg_file_sb_port: a single read port with bypass mux, busy lookup and out-of-range check. Instantiate it twice.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset mid-run:
  - Write reg3=0xDEADBEEF, then assert reset asynchronously between edges.
  - rd_data_a/b and busy_a/b drop to 0 immediately.
  - After release, reading reg3 gives 0.
- Write then read:
  - wr reg5=0x00000123 at cycle N, read rd_addr_a=5 at N+1.
  - rd_data_a=0x123 at N+2, busy_a=0.
- Bypass:
  - Same cycle wr reg7=0xCAFE0001 and rd_addr_a=rd_addr_b=7.
  - Next cycle both ports show 0xCAFE0001.
- Scoreboard:
  - rsv reg9 at N; read 9 shows busy_a=1.
  - Second rsv 9 at N+2 gives rsv_conflict=1 for exactly 1 cycle.
  - wr reg9=0x10 at N+3; read shows busy=0 and data 0x10.
- Simultaneous write+reserve:
  - wr reg4=0x55 and rsv reg4 in the same cycle while reg4 is busy.
  - No conflict; data 0x55, busy_a=1.
- Config DEPTH=12, ZERO_REG=1:
  - wr reg0=0xFF and wr reg13=0x1: both ignored.
  - Reads of 0 and 13 return 0/not busy.
  - rsv reg13 gives rsv_conflict=1.
